fifo_wr_packer: RTL

//  Write-side feeder for the async FIFO, in the wclk domain. Packs a stream of narrow IW-bit

---
 rtl/fifo_wr_packer.sv | 94 +++++++++
 1 files changed

// File: rtl/fifo_wr_packer.sv
// Write-side packer: IW-bit samples into WD-bit FIFO words (lane 0 first), honouring wfull.
// Build option FIFO_WR_PACKER_LOSSY_EN: never back-pressure, count dropped samples instead.
module fifo_wr_packer #(
  parameter int IW  = 8,
  parameter int WD  = 32,
  parameter int DCW = 16
) (
  input  logic           wclk,
  input  logic           rst,
  input  logic           s_valid,
  input  logic [IW-1:0]  s_data,
  output logic           s_ready,
  input  logic           flush,
  output logic           busy,
  output logic           wen,
  output logic [WD-1:0]  wdat,
  input  logic           wfull,
  output logic [DCW-1:0] drop_cnt
);
  localparam int N  = WD / IW;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [WD-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [WD-1:0] r_hold;
  logic          r_hold_v;
  logic          r_flush_pend;

  logic w_drain, w_hold_free, w_last, w_rdy, w_take;

  assign w_drain     = r_hold_v & ~wfull;
  assign w_hold_free = ~r_hold_v | w_drain;
  assign w_last      = (r_cnt == LAST);
  // The last lane may only be taken when the hold register can accept the finished word.
  assign w_rdy       = ~r_flush_pend & (~w_last | w_hold_free);
  assign w_take      = s_valid & w_rdy;

  assign wen  = w_drain;
  assign wdat = r_hold;
  assign busy = r_hold_v | (r_cnt != '0) | r_flush_pend;

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_v     <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_drain) r_hold_v <= 1'b0;
      if (r_flush_pend && w_hold_free) begin
        // Pending flush wins over a new flush pulse; the top lane of acc is always zero here.
        r_flush_pend <= 1'b0;
        if (r_cnt != '0) begin
          r_hold   <= r_acc;
          r_hold_v <= 1'b1;
          r_cnt    <= '0;
          r_acc    <= '0;
        end
      end else begin
        if (flush) r_flush_pend <= 1'b1;
        if (w_take) begin
          if (w_last) begin
            r_hold   <= {s_data, r_acc[WD-IW-1:0]};
            r_hold_v <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
          end else begin
            r_acc[r_cnt*IW +: IW] <= s_data;
            r_cnt                 <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef FIFO_WR_PACKER_LOSSY_EN
  logic [DCW-1:0] r_drop;
  logic           w_drop;

  assign w_drop   = s_valid & ~w_rdy;
  assign s_ready  = 1'b1;
  assign drop_cnt = r_drop;

  always_ff @(posedge wclk or posedge rst) begin
    if (rst)                         r_drop <= '0;
    else if (w_drop && r_drop != '1) r_drop <= r_drop + 1'b1;
  end
`else
  assign s_ready  = w_rdy;
  assign drop_cnt = '0;
`endif
endmodule
